store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-store entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  meaning the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  meaning reset, asynchronous and active-high.
REQ-004 SHALL have ports req_valid in 1 and req_ready out 1, meaning the CPU request handshake; transfer when both are high at the clock edge.
REQ-005 SHALL have ports req_we in 1 (1=store, 0=load), req_addr in 32 (byte address), req_wdata in 32 (store data) and req_memop in 3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010).
REQ-006 SHALL have ports resp_valid out 1, resp_rdata out 32 and misalign out 1, meaning a one-cycle response with load data and an alignment error flag.
REQ-007 SHALL have ports mem_addr out 32, mem_wdata out 32, mem_memop out 3, mem_we out 1 and mem_rdata in 32, meaning the data-memory port; both memory clocks are tied to clk.
REQ-008 SHALL have port empty out 1, meaning no stores are pending.

Function
REQ-009 SHALL hold stores in a circular FIFO of DEPTH entries of {addr, wdata, memop}, with wrap-around head and tail pointers and an occupancy count.
REQ-010 SHALL use states IDLE, LOAD_WAIT, DRAIN_RD and DRAIN_WR.
REQ-011 SHALL treat a request as misaligned when lh/lhu/sh has addr[0]=1, or lw/sw has addr[1:0]!=0.
REQ-012 SHALL not enqueue or issue a misaligned request; one cycle later it SHALL raise resp_valid=1 and misalign=1 with resp_rdata=0.
REQ-013 SHALL raise resp_valid exactly one cycle after every accepted request; for a store resp_rdata=0 (acknowledge only).
REQ-014 SHALL hold req_ready low when any of these is true: state is not IDLE; a store arrives with the FIFO full; a load word-matches (addr[31:2]) a pending entry that cannot be forwarded.
REQ-015 SHALL, for an accepted non-matching load in IDLE, drive mem_addr=req_addr, mem_memop=req_memop and mem_we=0 in the same cycle, then enter LOAD_WAIT and return resp_rdata=mem_rdata in the next cycle.
REQ-016 SHALL start a drain from IDLE when the FIFO is non-empty and no load is issued that cycle.
REQ-017 SHALL present the head entry with mem_we=1 for two consecutive cycles: DRAIN_RD, where memory captures the old word, then DRAIN_WR, where memory writes the merged word.
REQ-018 SHALL hold mem_addr, mem_wdata and mem_memop stable across both drain cycles, then pop the head and return to IDLE.
REQ-019 SHALL still accept stores during drain cycles when the FIFO is not full; simultaneous push and pop SHALL leave the count unchanged.
REQ-020 SHALL drive mem_we=0 in IDLE with no drain and in LOAD_WAIT.
REQ-021 SHALL deassert empty only when the count is nonzero or a drain is in progress.

Reset
REQ-022 SHALL, on rst, immediately clear the pointers and count, discard pending stores, and enter IDLE.
REQ-023 SHALL drive these values while rst is high: req_ready=0, resp_valid=0, resp_rdata=0, misalign=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_memop=0, empty=1.
REQ-024 SHALL, when rst asserts mid-drain, abandon the drain with no second write cycle; the memory word may hold the partial result.
REQ-025 SHALL raise req_ready in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with macro STORE_BUFFER_FWD_EN defined, forward a load that word-matches when the youngest matching entry is an sw: the byte or half is extracted, sign- or zero-extended per memop, returned with one-cycle latency, and no memory access occurs.
REQ-027 SHALL, without STORE_BUFFER_FWD_EN, stall every word-matching load until the matching entries have drained.

Verification
REQ-028 SHALL cover: sw 0x100=0xDEADBEEF, drain, lw 0x100 -> resp_rdata=0xDEADBEEF; mem_we high for exactly 2 cycles.
REQ-029 SHALL cover: with STORE_BUFFER_FWD_EN, sw 0x200=0x000080FF, then immediately lb 0x200 -> resp_rdata=0xFFFFFFFF one cycle later, with mem_we=0 and no memory read that cycle.
REQ-030 SHALL cover: without the macro, the same sequence -> req_ready low until the drain completes, then the load returns 0xFFFFFFFF.
REQ-031 SHALL cover: DEPTH+1 back-to-back stores with loads held off -> req_ready low on the (DEPTH+1)th store until the first drain pops; all stores land in order after pointer wrap.
REQ-032 SHALL cover: lw 0x102 -> resp_valid=1, misalign=1 and resp_rdata=0 one cycle later, with no memory access.
REQ-033 SHALL cover: rst asserted in DRAIN_RD with 3 entries pending -> empty=1 and mem_we=0 immediately, and no further writes occur.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the CPU and a read-modify-write data memory.
// Define STORE_BUFFER_FWD_EN to forward word-matching loads from a pending sw.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_memop,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN_RD, DRAIN_WR} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            resp_valid_q, resp_valid_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;

  logic [31:0]     addr_q  [DEPTH];
  logic [31:0]     wdata_q [DEPTH];
  logic [2:0]      op_q    [DEPTH];

  logic            full, misal, match_any, fwd_hit, load_block;
  logic            ready_raw, accept, push, pop, ld_issue, drain_start;
  logic [PW-1:0]   idx;
`ifdef STORE_BUFFER_FWD_EN
  logic            young_sw;
  logic [31:0]     young_data;
  logic [31:0]     fwd_data;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'b0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'b0, h};
      default: extract = w;
    endcase
  endfunction
`endif

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    misal = 1'b0;
    case (req_memop)
      3'b001, 3'b101: misal = req_addr[0];
      3'b010:         misal = |req_addr[1:0];
      default:        misal = 1'b0;
    endcase
  end

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    match_any = 1'b0;
    idx       = '0;
`ifdef STORE_BUFFER_FWD_EN
    young_sw   = 1'b0;
    young_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx][31:2] == req_addr[31:2])) begin
        match_any = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young_sw   = (op_q[idx] == 3'b010);
        young_data = wdata_q[idx];
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit  = match_any & young_sw;
  assign fwd_data = extract(young_data, req_addr[1:0], req_memop);
`else
  assign fwd_hit  = 1'b0;
`endif
  assign load_block = match_any & ~fwd_hit;

  // Loads are only taken in IDLE; stores may also slip in while draining.
  always_comb begin
    ready_raw = 1'b0;
    case (state_q)
      IDLE:               ready_raw = req_we ? ~full : (misal | ~load_block);
      DRAIN_RD, DRAIN_WR: ready_raw = req_we & ~full;
      default:            ready_raw = 1'b0;
    endcase
  end

  assign req_ready   = ready_raw & ~rst;
  assign accept      = req_valid & req_ready;
  assign push        = accept & req_we & ~misal;
  assign ld_issue    = accept & ~req_we & ~misal & ~fwd_hit;
  assign pop         = (state_q == DRAIN_WR);
  assign drain_start = (state_q == IDLE) && (count_q != '0) && !accept;

  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_memop = '0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_issue) begin
          state_d   = LOAD_WAIT;
          mem_addr  = req_addr;
          mem_memop = req_memop;
        end else if (drain_start) begin
          state_d = DRAIN_RD;
        end
      end
      LOAD_WAIT: state_d = IDLE;
      DRAIN_RD, DRAIN_WR: begin
        state_d   = (state_q == DRAIN_RD) ? DRAIN_WR : IDLE;
        mem_we    = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = wdata_q[head_q];
        mem_memop = op_q[head_q];
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d       = pop ? head_q + PW'(1) : head_q;
    tail_d       = push ? tail_q + PW'(1) : tail_q;
    count_d      = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    resp_valid_d = accept;
    misalign_d   = accept & misal;
    resp_rdata_d = '0;
`ifdef STORE_BUFFER_FWD_EN
    if (accept && !req_we && !misal && fwd_hit) resp_rdata_d = fwd_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      misalign_q   <= misalign_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Entry payload needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q]  <= req_addr;
      wdata_q[tail_q] <= req_wdata;
      op_q[tail_q]    <= req_memop;
    end
  end

  assign resp_valid = resp_valid_q;
  assign misalign   = misalign_q;
  assign resp_rdata = (state_q == LOAD_WAIT) ? mem_rdata : resp_rdata_q;
  assign empty      = (count_q == '0) && (state_q != DRAIN_RD) && (state_q != DRAIN_WR);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a read-modify-write memory model.
// Expectations adapt to whether STORE_BUFFER_FWD_EN is defined.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_memop;
  logic        resp_valid, misalign;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  bit [31:0]   mem [1024];
  int          weCount = 0;
  logic [31:0] writeLog [$];
  logic        phase = 1'b0;
  logic [31:0] oldWord = '0;
  logic [31:0] memRdata = '0;

  assign mem_rdata = memRdata;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_memop(req_memop),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memop(mem_memop),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] op, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (op[1:0])
      2'b00:   r[int'(a)*8 +: 8] = wd[7:0];
      2'b01:   if (a[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] w, input logic [2:0] op,
                                             input logic [1:0] a);
    logic [31:0] s;
    s = w >> (int'(a) * 8);
    case (op)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory: first write cycle captures the old word, second writes the merge.
  always @(posedge clk) begin
    if (mem_we) weCount++;
    if (rst) begin
      phase <= 1'b0;
    end else if (mem_we) begin
      if (!phase) begin
        oldWord <= mem[mem_addr[11:2]];
        phase   <= 1'b1;
      end else begin
        mem[mem_addr[11:2]] <= mergeWord(oldWord, mem_wdata, mem_memop, mem_addr[1:0]);
        writeLog.push_back(mem_addr);
        phase <= 1'b0;
      end
    end else begin
      phase    <= 1'b0;
      memRdata <= loadExtend(mem[mem_addr[11:2]], mem_memop, mem_addr[1:0]);
    end
  end

  // Call just after a negedge; returns at the negedge where the response shows.
  task automatic sendReq(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op, output int stalls, output logic rv,
                         output logic [31:0] rd, output logic mis, output logic accWe,
                         output logic [31:0] accAddr);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_memop = op;
    #1;
    stalls = 0;
    while (req_ready !== 1'b1 && stalls < 60) begin
      @(negedge clk); #1;
      stalls++;
    end
    accWe = mem_we;
    accAddr = mem_addr;
    @(negedge clk);
    rv = resp_valid; rd = resp_rdata; mis = misalign;
  endtask

  int          st;
  logic        rv, mis, aw;
  logic [31:0] rd, aa;

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_memop = '0;
    #2;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready got %b want 0", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_resp_valid got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_rdata got %h want 0", resp_rdata); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_misalign got %b want 0", misalign); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_we got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_memop !== 3'h0) begin miscompares++; $display("[TB] FAIL rst_mem_bus got %h/%h/%h want 0", mem_addr, mem_wdata, mem_memop); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_empty got %b want 1", empty); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_store_drain();
    int base, cyc, weCycles;
    @(negedge clk);
    base = weCount;
    sendReq(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, st, rv, rd, mis, aw, aa);
    req_valid = 1'b0;
    vectors++; if (st !== 0) begin miscompares++; $display("[TB] FAIL sw_stall got %0d want 0", st); end
    vectors++; if (rv !== 1'b1 || rd !== 32'h0 || mis !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_ack got v=%b d=%h m=%b want 1/0/0", rv, rd, mis); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_pending_empty got %b want 0", empty); end
    cyc = 0; weCycles = 0;
    while (empty !== 1'b1 && cyc < 50) begin
      if (mem_we === 1'b1) begin
        weCycles++;
        vectors++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF || mem_memop !== 3'b010) begin miscompares++; $display("[TB] FAIL drain_bus got %h/%h/%h want 100/deadbeef/2", mem_addr, mem_wdata, mem_memop); end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++; if (cyc >= 50) begin miscompares++; $display("[TB] FAIL drain_timeout got %0d cycles want <50", cyc); end
    vectors++; if (weCycles !== 2 || (weCount - base) !== 2) begin miscompares++; $display("[TB] FAIL drain_we_cycles got %0d/%0d want 2", weCycles, weCount - base); end
    vectors++; if (mem[32'h100 >> 2] !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL drain_mem got %h want deadbeef", mem[32'h100 >> 2]); end
    sendReq(1'b0, 32'h100, 32'h0, 3'b010, st, rv, rd, mis, aw, aa);
    req_valid = 1'b0;
    vectors++; if (st !== 0 || aw !== 1'b0 || aa !== 32'h100) begin miscompares++; $display("[TB] FAIL lw_issue got st=%0d we=%b a=%h want 0/0/100", st, aw, aa); end
    vectors++; if (rv !== 1'b1 || rd !== 32'hDEADBEEF || mis !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_data got v=%b d=%h m=%b want 1/deadbeef/0", rv, rd, mis); end
  endtask

  task automatic test_load_match();
    int base, cyc;
    logic [31:0] addrs [4];
    logic [2:0]  ops [4];
    logic [31:0] exps [4];
    addrs = '{32'h200, 32'h201, 32'h200, 32'h202};
    ops   = '{3'b000, 3'b100, 3'b001, 3'b101};
    exps  = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00000000};
    @(negedge clk);
    base = weCount;
    sendReq(1'b1, 32'h200, 32'h000080FF, 3'b010, st, rv, rd, mis, aw, aa);
    vectors++; if (st !== 0 || rv !== 1'b1) begin miscompares++; $display("[TB] FAIL match_sw got st=%0d v=%b want 0/1", st, rv); end
    for (int i = 0; i < 4; i++) begin
      sendReq(1'b0, addrs[i], 32'h0, ops[i], st, rv, rd, mis, aw, aa);
      vectors++; if (st !== (FWD ? 0 : (i == 0 ? 3 : 1))) begin miscompares++; $display("[TB] FAIL match_stall%0d got %0d want %0d", i, st, FWD ? 0 : (i == 0 ? 3 : 1)); end
      vectors++; if (aw !== 1'b0 || aa !== (FWD ? 32'h0 : addrs[i])) begin miscompares++; $display("[TB] FAIL match_mem%0d got we=%b a=%h", i, aw, aa); end
      vectors++; if (rv !== 1'b1 || rd !== exps[i] || mis !== 1'b0) begin miscompares++; $display("[TB] FAIL match_data%0d got v=%b d=%h want 1/%h", i, rv, rd, exps[i]); end
    end
    req_valid = 1'b0;
    cyc = 0;
    while (empty !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    vectors++; if (cyc >= 50 || (weCount - base) !== 2) begin miscompares++; $display("[TB] FAIL match_drain got cyc=%0d we=%0d want <50/2", cyc, weCount - base); end
    vectors++; if (mem[32'h200 >> 2] !== 32'h000080FF) begin miscompares++; $display("[TB] FAIL match_mem_word got %h want 000080ff", mem[32'h200 >> 2]); end
  endtask

  task automatic test_misalign();
    int base;
    @(negedge clk);
    base = weCount;
    sendReq(1'b0, 32'h102, 32'h0, 3'b010, st, rv, rd, mis, aw, aa);
    vectors++; if (st !== 0 || aw !== 1'b0 || aa !== 32'h0) begin miscompares++; $display("[TB] FAIL mis_lw_mem got st=%0d we=%b a=%h want 0/0/0", st, aw, aa); end
    vectors++; if (rv !== 1'b1 || mis !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL mis_lw_resp got v=%b m=%b d=%h want 1/1/0", rv, mis, rd); end
    sendReq(1'b0, 32'h101, 32'h0, 3'b101, st, rv, rd, mis, aw, aa);
    vectors++; if (st !== 0 || rv !== 1'b1 || mis !== 1'b1 || rd !== 32'h0 || aa !== 32'h0) begin miscompares++; $display("[TB] FAIL mis_lhu got st=%0d v=%b m=%b d=%h a=%h", st, rv, mis, rd, aa); end
    sendReq(1'b1, 32'h203, 32'h12345678, 3'b010, st, rv, rd, mis, aw, aa);
    vectors++; if (rv !== 1'b1 || mis !== 1'b1 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_sw got v=%b m=%b empty=%b want 1/1/1", rv, mis, empty); end
    sendReq(1'b0, 32'h102, 32'h0, 3'b001, st, rv, rd, mis, aw, aa);
    req_valid = 1'b0;
    vectors++; if (st !== 0 || aa !== 32'h102 || rv !== 1'b1 || mis !== 1'b0 || rd !== 32'hFFFFDEAD) begin miscompares++; $display("[TB] FAIL aligned_lh got st=%0d a=%h v=%b m=%b d=%h want d=ffffdead", st, aa, rv, mis, rd); end
    repeat (4) @(negedge clk);
    vectors++; if (weCount !== base) begin miscompares++; $display("[TB] FAIL mis_no_write got %0d want %0d", weCount, base); end
  endtask

  task automatic test_back_to_back();
    int base, cyc;
    @(negedge clk);
    base = writeLog.size();
    for (int i = 0; i <= DEPTH; i++) begin
      sendReq(1'b1, 32'h300 + 32'(4 * i), 32'hA0000000 + 32'(i), 3'b010, st, rv, rd, mis, aw, aa);
      vectors++; if (st !== (i == DEPTH ? 3 : 0) || rv !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_store%0d got st=%0d v=%b want %0d/1", i, st, rv, i == DEPTH ? 3 : 0); end
    end
    req_valid = 1'b0;
    cyc = 0;
    while (empty !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    vectors++; if (cyc >= 200 || writeLog.size() - base !== DEPTH + 1) begin miscompares++; $display("[TB] FAIL b2b_count got cyc=%0d writes=%0d want %0d", cyc, writeLog.size() - base, DEPTH + 1); end
    for (int i = 0; i <= DEPTH; i++) begin
      if (base + i < writeLog.size()) begin
        vectors++; if (writeLog[base + i] !== 32'h300 + 32'(4 * i)) begin miscompares++; $display("[TB] FAIL b2b_order%0d got %h want %h", i, writeLog[base + i], 32'h300 + 32'(4 * i)); end
      end
      vectors++; if (mem[(32'h300 >> 2) + i] !== 32'hA0000000 + 32'(i)) begin miscompares++; $display("[TB] FAIL b2b_data%0d got %h want %h", i, mem[(32'h300 >> 2) + i], 32'hA0000000 + 32'(i)); end
    end
  endtask

  task automatic test_reset_drain();
    int baseWe, baseLog;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      sendReq(1'b1, 32'h400 + 32'(4 * i), 32'h55550000 + 32'(i), 3'b010, st, rv, rd, mis, aw, aa);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_rst_drain got we=%b empty=%b want 1/0", mem_we, empty); end
    rst = 1'b1;
    #1;
    baseWe = weCount; baseLog = writeLog.size();
    vectors++; if (empty !== 1'b1 || mem_we !== 1'b0 || req_ready !== 1'b0 || mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_drain got empty=%b we=%b rdy=%b a=%h", empty, mem_we, req_ready, mem_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst2_ready got %b want 1", req_ready); end
    repeat (10) @(negedge clk);
    vectors++; if (weCount !== baseWe || writeLog.size() !== baseLog) begin miscompares++; $display("[TB] FAIL rst_no_writes got we=%0d log=%0d want %0d/%0d", weCount, writeLog.size(), baseWe, baseLog); end
    vectors++; if (mem[32'h400 >> 2] !== 32'h0 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_discard got mem=%h empty=%b want 0/1", mem[32'h400 >> 2], empty); end
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_load_match();
    test_misalign();
    test_back_to_back();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
